// File: rtl/task_stream_receiver.sv
// rtl/task_stream_receiver.sv - receiving end of the task injector flit link
//
// Decodes application descriptors arriving as credit-flow-controlled flits:
//   D, N, N x (mapping, ttt), D graph words,
//   N x (text, data, bss, entry, (text+data)/4 binary words).
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   rx_i, credit_o, data_i   flit link; a transfer is rx_i && credit_o
//   eoa_i                    transmitter has no more applications
//   map_valid_o/task/addr/ttt  one pulse per mapping pair (with the TTT flit)
//   graph_valid_o/word       one pulse per graph word
//   hdr_valid_o/task, text_size_o, data_size_o, bss_size_o, entry_o
//                            pulse after a task header plus latched fields
//   wr_en_o/addr/data, wr_ready_i  binary word write port, zero latency
//   app_done_o               pulse after the last task binary of an application
//   eoa_o, err_o             sticky end-of-applications / protocol error
module task_stream_receiver #(
  parameter int FLIT_SIZE = 32,
  parameter int MAX_TASKS = 32,
  parameter int ADDR_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic                 credit_o,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 eoa_i,
  output logic                 map_valid_o,
  output logic [7:0]           map_task_o,
  output logic [FLIT_SIZE-1:0] map_addr_o,
  output logic [FLIT_SIZE-1:0] map_ttt_o,
  output logic                 graph_valid_o,
  output logic [FLIT_SIZE-1:0] graph_word_o,
  output logic                 hdr_valid_o,
  output logic [7:0]           hdr_task_o,
  output logic [FLIT_SIZE-1:0] text_size_o,
  output logic [FLIT_SIZE-1:0] data_size_o,
  output logic [FLIT_SIZE-1:0] bss_size_o,
  output logic [FLIT_SIZE-1:0] entry_o,
  output logic                 wr_en_o,
  output logic [ADDR_W-1:0]    wr_addr_o,
  output logic [FLIT_SIZE-1:0] wr_data_o,
  input  logic                 wr_ready_i,
  output logic                 app_done_o,
  output logic                 eoa_o,
  output logic                 err_o
);

  // Binary length in words is (text+data)>>2, so two bits narrower than a flit.
  // wr_addr_o is the low ADDR_W bits of this counter (ADDR_W <= FLIT_SIZE-2).
  localparam int WW = FLIT_SIZE - 2;

  typedef enum logic [3:0] {
    S_DSIZE, S_CNT, S_MAP, S_TTT, S_GRAPH, S_TEXT, S_DATA,
    S_BSS, S_ENTRY, S_BIN, S_TEND, S_EOA, S_ERR
  } state_e;

  state_e               state_q, state_d;
  logic [FLIT_SIZE-1:0] gcnt_q, gcnt_d;
  logic [7:0]           ntask_q, ntask_d;
  logic [7:0]           tidx_q, tidx_d;
  logic [FLIT_SIZE-1:0] map_q, map_d;
  logic [FLIT_SIZE-1:0] text_q, text_d;
  logic [FLIT_SIZE-1:0] data_q, data_d;
  logic [FLIT_SIZE-1:0] bss_q, bss_d;
  logic [FLIT_SIZE-1:0] entry_q, entry_d;
  logic [WW-1:0]        wlen_q, wlen_d;
  logic [WW-1:0]        wcnt_q, wcnt_d;
  logic                 hdr_valid_q, hdr_valid_d;

  logic                 xfer;
  logic                 last_task;
  logic [FLIT_SIZE:0]   bin_bytes;

  assign xfer      = rx_i && credit_o;
  assign last_task = (tidx_q == ntask_q - 8'd1);
  // Extra top bit catches a text+data sum that overflows the flit width.
  assign bin_bytes = {1'b0, text_q} + {1'b0, data_q};

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_DSIZE;
      gcnt_q      <= '0;
      ntask_q     <= '0;
      tidx_q      <= '0;
      map_q       <= '0;
      text_q      <= '0;
      data_q      <= '0;
      bss_q       <= '0;
      entry_q     <= '0;
      wlen_q      <= '0;
      wcnt_q      <= '0;
      hdr_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gcnt_q      <= gcnt_d;
      ntask_q     <= ntask_d;
      tidx_q      <= tidx_d;
      map_q       <= map_d;
      text_q      <= text_d;
      data_q      <= data_d;
      bss_q       <= bss_d;
      entry_q     <= entry_d;
      wlen_q      <= wlen_d;
      wcnt_q      <= wcnt_d;
      hdr_valid_q <= hdr_valid_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    gcnt_d      = gcnt_q;
    ntask_d     = ntask_q;
    tidx_d      = tidx_q;
    map_d       = map_q;
    text_d      = text_q;
    data_d      = data_q;
    bss_d       = bss_q;
    entry_d     = entry_q;
    wlen_d      = wlen_q;
    wcnt_d      = wcnt_q;
    hdr_valid_d = 1'b0;

    unique case (state_q)
      S_DSIZE: begin
        // A flit offered together with eoa_i still starts a new application.
        if (xfer) begin
          gcnt_d  = data_i;
          state_d = S_CNT;
        end else if (eoa_i) begin
          state_d = S_EOA;
        end
      end
      S_CNT: begin
        if (xfer) begin
          tidx_d = '0;
          if (data_i == '0 || data_i > FLIT_SIZE'(MAX_TASKS)) begin
            state_d = S_ERR;
          end else begin
            ntask_d = data_i[7:0];
            state_d = S_MAP;
          end
        end
      end
      S_MAP: begin
        if (xfer) begin
          map_d   = data_i;
          state_d = S_TTT;
        end
      end
      S_TTT: begin
        if (xfer) begin
          if (!last_task) begin
            tidx_d  = tidx_q + 8'd1;
            state_d = S_MAP;
          end else if (gcnt_q != '0) begin
            tidx_d  = tidx_q + 8'd1;
            state_d = S_GRAPH;
          end else begin
            // No graph words: go straight to the headers with task 0.
            tidx_d  = '0;
            state_d = S_TEXT;
          end
        end
      end
      S_GRAPH: begin
        if (xfer) begin
          gcnt_d = gcnt_q - 1'b1;
          if (gcnt_q == FLIT_SIZE'(1)) begin
            tidx_d  = '0;
            state_d = S_TEXT;
          end
        end
      end
      S_TEXT: begin
        if (xfer) begin
          text_d  = data_i;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          data_d  = data_i;
          state_d = S_BSS;
        end
      end
      S_BSS: begin
        if (xfer) begin
          bss_d   = data_i;
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (xfer) begin
          entry_d     = data_i;
          hdr_valid_d = 1'b1;
          if (bin_bytes[FLIT_SIZE] || bin_bytes[1:0] != 2'b00) begin
            state_d = S_ERR;
          end else if (bin_bytes[FLIT_SIZE-1:2] == '0) begin
            state_d = S_TEND;
          end else begin
            wlen_d  = bin_bytes[FLIT_SIZE-1:2];
            wcnt_d  = '0;
            state_d = S_BIN;
          end
        end
      end
      S_BIN: begin
        if (xfer) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == wlen_q - 1'b1) state_d = S_TEND;
        end
      end
      S_TEND: begin
        if (last_task) begin
          state_d = S_DSIZE;
        end else begin
          tidx_d  = tidx_q + 8'd1;
          state_d = S_TEXT;
        end
      end
      S_EOA:   state_d = S_EOA;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Outputs
  always_comb begin
    credit_o      = 1'b0;
    map_valid_o   = 1'b0;
    map_ttt_o     = '0;
    graph_valid_o = 1'b0;
    graph_word_o  = '0;
    wr_en_o       = 1'b0;
    wr_data_o     = '0;
    app_done_o    = 1'b0;

    unique case (state_q)
      S_DSIZE, S_CNT, S_MAP, S_GRAPH, S_TEXT, S_DATA, S_BSS, S_ENTRY: credit_o = 1'b1;
      S_TTT: begin
        credit_o    = 1'b1;
        map_valid_o = rx_i;
        map_ttt_o   = rx_i ? data_i : '0;
      end
      S_BIN:  credit_o = wr_ready_i;
      S_TEND: app_done_o = last_task;
      default: credit_o = 1'b0;
    endcase

    if (state_q == S_GRAPH && rx_i) begin
      graph_valid_o = 1'b1;
      graph_word_o  = data_i;
    end
    if (state_q == S_BIN && rx_i && wr_ready_i) begin
      wr_en_o   = 1'b1;
      wr_data_o = data_i;
    end
  end

  assign map_task_o  = tidx_q;
  assign map_addr_o  = map_q;
  assign hdr_valid_o = hdr_valid_q;
  assign hdr_task_o  = tidx_q;
  assign text_size_o = text_q;
  assign data_size_o = data_q;
  assign bss_size_o  = bss_q;
  assign entry_o     = entry_q;
  assign wr_addr_o   = wcnt_q[ADDR_W-1:0];
  assign eoa_o       = (state_q == S_EOA);
  assign err_o       = (state_q == S_ERR);

endmodule

// File: tb/tb_task_stream_receiver.sv
// tb/tb_task_stream_receiver.sv - randomized bench for task_stream_receiver
module tb_task_stream_receiver;
  localparam int AW = 3;
  localparam int MT = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b0;
  logic        credit_o;
  logic [31:0] din = '0;
  logic        eoa = 1'b0;
  logic        map_valid_o;
  logic [7:0]  map_task_o;
  logic [31:0] map_addr_o, map_ttt_o;
  logic        graph_valid_o;
  logic [31:0] graph_word_o;
  logic        hdr_valid_o;
  logic [7:0]  hdr_task_o;
  logic [31:0] text_size_o, data_size_o, bss_size_o, entry_o;
  logic        wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [31:0] wr_data_o;
  logic        wr_ready = 1'b1;
  logic        app_done_o, eoa_o, err_o;

  task_stream_receiver #(.FLIT_SIZE(32), .MAX_TASKS(MT), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .credit_o(credit_o), .data_i(din),
    .eoa_i(eoa), .map_valid_o(map_valid_o), .map_task_o(map_task_o),
    .map_addr_o(map_addr_o), .map_ttt_o(map_ttt_o), .graph_valid_o(graph_valid_o),
    .graph_word_o(graph_word_o), .hdr_valid_o(hdr_valid_o), .hdr_task_o(hdr_task_o),
    .text_size_o(text_size_o), .data_size_o(data_size_o), .bss_size_o(bss_size_o),
    .entry_o(entry_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .wr_ready_i(wr_ready), .app_done_o(app_done_o), .eoa_o(eoa_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; bit bin; } flit_t;
  typedef struct { int t; logic [31:0] a; logic [31:0] ttt; } map_t;
  typedef struct { int t; logic [31:0] tx, da, bs, en; } hdr_t;
  typedef struct { int a; logic [31:0] d; } wr_t;

  flit_t       flits[$];
  map_t        exp_map[$];
  logic [31:0] exp_graph[$];
  hdr_t        exp_hdr[$];
  wr_t         exp_wr[$];
  int          exp_done = 0;
  int          wr_seen = 0;
  bit          ignore_hdr = 0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input bit bin);
    flit_t f;
    f.d = d; f.bin = bin;
    flits.push_back(f);
  endtask

  task automatic push_map(input int t, input logic [31:0] a, input logic [31:0] ttt);
    map_t m;
    push(a, 0); push(ttt, 0);
    m.t = t; m.a = a; m.ttt = ttt;
    exp_map.push_back(m);
  endtask

  task automatic push_graph(input logic [31:0] w);
    push(w, 0);
    exp_graph.push_back(w);
  endtask

  // One task header plus (text+data)/4 random binary words.
  task automatic push_task(input int t, input logic [31:0] tx, input logic [31:0] da,
                           input logic [31:0] bs, input logic [31:0] en);
    hdr_t h;
    wr_t  w;
    push(tx, 0); push(da, 0); push(bs, 0); push(en, 0);
    h.t = t; h.tx = tx; h.da = da; h.bs = bs; h.en = en;
    exp_hdr.push_back(h);
    for (int i = 0; i < int'((tx + da) / 4); i++) begin
      w.a = i % (1 << AW);
      w.d = $urandom;
      push(w.d, 1);
      exp_wr.push_back(w);
    end
  endtask

  task automatic random_app(input int n);
    int d;
    d = $urandom_range(0, 3);
    push(d, 0); push(n, 0);
    for (int i = 0; i < n; i++)
      push_map(i, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom);
    for (int i = 0; i < d; i++) push_graph($urandom);
    for (int i = 0; i < n; i++)
      push_task(i, 4 * $urandom_range(0, 6), 4 * $urandom_range(0, 4), $urandom, $urandom);
    exp_done++;
  endtask

  task automatic monitor();
    map_t m;
    hdr_t h;
    wr_t  w;
    if (map_valid_o) begin
      if (exp_map.size() == 0) check("map_extra", 1, 0);
      else begin
        m = exp_map.pop_front();
        check("map_task", map_task_o, m.t);
        check("map_addr", map_addr_o, m.a);
        check("map_ttt", map_ttt_o, m.ttt);
      end
    end
    if (graph_valid_o) begin
      if (exp_graph.size() == 0) check("graph_extra", 1, 0);
      else check("graph_word", graph_word_o, exp_graph.pop_front());
    end
    if (hdr_valid_o && !ignore_hdr) begin
      if (exp_hdr.size() == 0) check("hdr_extra", 1, 0);
      else begin
        h = exp_hdr.pop_front();
        check("hdr_task", hdr_task_o, h.t);
        check("hdr_text", text_size_o, h.tx);
        check("hdr_data", data_size_o, h.da);
        check("hdr_bss", bss_size_o, h.bs);
        check("hdr_entry", entry_o, h.en);
      end
    end
    if (wr_en_o) begin
      wr_seen++;
      if (exp_wr.size() == 0) check("wr_extra", 1, 0);
      else begin
        w = exp_wr.pop_front();
        check("wr_addr", wr_addr_o, w.a);
        check("wr_data", wr_data_o, w.d);
      end
    end
    if (app_done_o) begin
      if (exp_done == 0) check("done_extra", 1, 0);
      else exp_done--;
    end
    // While a binary word is next on the link the receiver follows the memory.
    if (flits.size() > 0 && flits[0].bin) check("bin_credit", credit_o, wr_ready);
  endtask

  task automatic drive();
    wr_ready = ($urandom_range(0, 3) != 0);
    if (flits.size() > 0 && $urandom_range(0, 3) != 0) begin
      rx = 1'b1; din = flits[0].d;
    end else begin
      rx = 1'b0; din = $urandom;
    end
  endtask

  task automatic cycle();
    bit x;
    @(negedge clk);
    monitor();
    x = rx && credit_o;
    @(posedge clk);
    #1;
    if (x) void'(flits.pop_front());
    drive();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (flits.size() > 0 && n < 20000) begin cycle(); n++; end
    for (int i = 0; i < 4; i++) cycle();
    check({tag, "_flits_left"}, flits.size(), 0);
    check({tag, "_maps_left"}, exp_map.size(), 0);
    check({tag, "_graph_left"}, exp_graph.size(), 0);
    check({tag, "_hdr_left"}, exp_hdr.size(), 0);
    check({tag, "_wr_left"}, exp_wr.size(), 0);
    check({tag, "_done_left"}, exp_done, 0);
    check({tag, "_no_err"}, err_o, 0);
  endtask

  task automatic do_reset();
    rx = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst_err", err_o, 0);
    check("rst_eoa", eoa_o, 0);
    check("rst_wr_en", wr_en_o, 0);
    check("rst_text", text_size_o, 0);
    check("rst_wr_addr", wr_addr_o, 0);
    flits.delete(); exp_map.delete(); exp_graph.delete(); exp_hdr.delete(); exp_wr.delete();
    exp_done = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic expect_err(input string tag);
    for (int i = 0; i < 20; i++) cycle();
    check({tag, "_err"}, err_o, 1);
    check({tag, "_credit"}, credit_o, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_credit", credit_o, 1);
    check("reset_err", err_o, 0);
    check("reset_eoa", eoa_o, 0);
    check("reset_map_valid", map_valid_o, 0);
    check("reset_hdr_valid", hdr_valid_o, 0);
    check("reset_done", app_done_o, 0);
    check("reset_entry", entry_o, 0);
    rst_n = 1'b1;

    // Reference application from the plan.
    push(2, 0); push(1, 0);
    push_map(0, 32'h0101, 32'hFFFF_FFFF);
    push_graph(5); push_graph(7);
    push_task(0, 8, 4, 32'h10, 32'h20);
    exp_done++;
    drain("plan1");

    // N=2, D=0, first task has an empty binary.
    push(0, 0); push(2, 0);
    push_map(0, $urandom, $urandom); push_map(1, $urandom, $urandom);
    push_task(0, 0, 0, 32'h1, 32'h2);
    push_task(1, 4, 0, 32'h3, 32'h4);
    exp_done++;
    drain("plan3");

    // Random applications, one of them at the largest legal task count.
    for (int a = 0; a < 12; a++) random_app((a == 4) ? MT : $urandom_range(1, 4));
    drain("random");

    // Misaligned binary size.
    ignore_hdr = 1;
    push(0, 0); push(1, 0); push_map(0, 32'h55, 32'h66);
    push(6, 0); push(0, 0); push(32'h7, 0); push(32'h8, 0);
    push(32'hDEAD, 0); push(32'hBEEF, 0);
    expect_err("misalign");
    check("misalign_map_seen", exp_map.size(), 0);
    do_reset();
    ignore_hdr = 0;

    // Illegal task counts.
    push(1, 0); push(0, 0); push(32'h9, 0);
    expect_err("n_zero");
    do_reset();
    push(0, 0); push(MT + 1, 0); push(32'h9, 0);
    expect_err("n_over");
    do_reset();
    random_app(3);
    drain("after_err");

    // Reset while a binary is streaming.
    wr_seen = 0;
    push(0, 0); push(1, 0); push_map(0, 32'h1, 32'h2);
    push_task(0, 32, 0, 32'h3, 32'h4);
    exp_done++;
    for (int i = 0; i < 500 && wr_seen < 3; i++) cycle();
    check("bin_reached", wr_seen >= 3, 1);
    do_reset();
    random_app(2);
    drain("after_rst");

    // End of applications while idle.
    rx = 1'b0;
    eoa = 1'b1;
    @(posedge clk);
    #1;
    check("eoa_flag", eoa_o, 1);
    check("eoa_credit", credit_o, 0);
    repeat (3) @(posedge clk);
    #1;
    check("eoa_sticky", eoa_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
